// File: rtl/aes_gcm_ghash_engine.sv
// GHASH/tag engine for AES-GCM: folds masked AAD and ciphertext blocks into S with a
// digit-serial GF(2^128) multiplier, then absorbs len(A)||len(C) and returns S ^ E(K,J0).
//
// state  | meaning
// IDLE   | S = 0, waiting for i_start to capture H, EJ0 and lengths
// ABSORB | o_blk_ready high while data blocks remain; handshake loads S ^ X
// MULT   | MULT_CYC cycles of the Z/V shift-add loop, DIGIT_BITS bits of H per cycle
// LEN    | loads S ^ (len(A) || len(C)) into the multiplier
// TAG    | o_tag/o_tag_valid held until i_tag_ready
module aes_gcm_ghash_engine #(
  parameter int DIGIT_BITS = 8,
  parameter int TAG_BITS   = 128
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:63]  i_aad_bits,
  input  logic [0:63]  i_text_bits,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [0:127] i_blk_data,
  output logic         o_tag_valid,
  input  logic         i_tag_ready,
  output logic [0:127] o_tag,
  output logic         o_busy,
  output logic         o_err
);

  localparam int MULT_CYC = 128 / DIGIT_BITS;
  localparam int CNT_W    = $clog2(MULT_CYC + 1);
  localparam logic [0:127] R_POLY = {8'hE1, 120'd0};

  function automatic logic [0:127] lead_mask(input int n);
    logic [0:127] m;
    for (int i = 0; i < 128; i++) m[i] = (i < n);
    return m;
  endfunction

  localparam logic [0:127] TAG_MASK = lead_mask(TAG_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABSORB = 3'd1,
    S_MULT   = 3'd2,
    S_LEN    = 3'd3,
    S_TAG    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [0:127]     r_h;
  logic [0:127]     r_ej0;
  logic [0:63]      r_aad_bits;
  logic [0:63]      r_text_bits;
  logic [63:0]      r_na_left;
  logic [63:0]      r_nc_left;
  logic [0:127]     r_s;
  logic [0:127]     r_z;
  logic [0:127]     r_v;
  logic [0:127]     r_hsh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_final;
  logic [0:127]     r_tag;
  logic             r_tag_valid;
  logic             r_err;

  logic [63:0]  w_na_init;
  logic [63:0]  w_nc_init;
  logic         w_blocks_left;
  logic         w_is_aad;
  logic         w_last_of_kind;
  logic [6:0]   w_last_bits;
  logic [0:127] w_mask;
  logic [0:127] w_blk;
  logic         w_ready;
  logic         w_hs;
  logic         w_mult_done;
  logic [0:127] w_z;
  logic [0:127] w_v;
  logic [0:127] w_hsh_nxt;

  // Carry-safe ceil(len/128): no overflow even at len = 2^64-1.
  assign w_na_init = (i_aad_bits >> 7) + {63'd0, |i_aad_bits[57:63]};
  assign w_nc_init = (i_text_bits >> 7) + {63'd0, |i_text_bits[57:63]};

  assign w_blocks_left  = (r_na_left != 64'd0) || (r_nc_left != 64'd0);
  assign w_is_aad       = (r_na_left != 64'd0);
  assign w_last_of_kind = w_is_aad ? (r_na_left == 64'd1) : (r_nc_left == 64'd1);
  assign w_last_bits    = w_is_aad ? r_aad_bits[57:63] : r_text_bits[57:63];
  assign w_mask         = (w_last_of_kind && (w_last_bits != 7'd0))
                          ? ~({128{1'b1}} >> w_last_bits) : {128{1'b1}};
  assign w_blk          = i_blk_data & w_mask;
  assign w_hs           = w_ready && i_blk_valid;
  assign w_mult_done    = (r_cnt == CNT_W'(1));

  // One digit of the Z/V loop: Z ^= V for each set H bit, V = V*x mod the GCM polynomial.
  always_comb begin
    w_z = r_z;
    w_v = r_v;
    for (int d = 0; d < DIGIT_BITS; d++) begin
      if (r_hsh[d]) w_z = w_z ^ w_v;
      w_v = w_v[127] ? ((w_v >> 1) ^ R_POLY) : (w_v >> 1);
    end
  end

  generate
    if (DIGIT_BITS == 128) begin : g_full_digit
      assign w_hsh_nxt = '0;
    end else begin : g_part_digit
      assign w_hsh_nxt = {r_hsh[DIGIT_BITS:127], {DIGIT_BITS{1'b0}}};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_ABSORB;
      end
      S_ABSORB: begin
        if (!w_blocks_left) begin
          w_state_nxt = S_LEN;
        end else begin
          w_ready = 1'b1;
          if (i_blk_valid) w_state_nxt = S_MULT;
        end
      end
      S_MULT: begin
        if (w_mult_done) begin
          if (r_final)            w_state_nxt = S_TAG;
          else if (w_blocks_left) w_state_nxt = S_ABSORB;
          else                    w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        w_state_nxt = S_MULT;
      end
      S_TAG: begin
        if (i_tag_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h         <= '0;
      r_ej0       <= '0;
      r_aad_bits  <= '0;
      r_text_bits <= '0;
      r_na_left   <= '0;
      r_nc_left   <= '0;
      r_s         <= '0;
      r_z         <= '0;
      r_v         <= '0;
      r_hsh       <= '0;
      r_cnt       <= '0;
      r_final     <= 1'b0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= i_start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_h         <= i_h;
            r_ej0       <= i_encrypted_j0;
            r_aad_bits  <= i_aad_bits;
            r_text_bits <= i_text_bits;
            r_na_left   <= w_na_init;
            r_nc_left   <= w_nc_init;
          end
        end
        S_ABSORB: begin
          if (w_hs) begin
            r_v   <= r_s ^ w_blk;
            r_z   <= '0;
            r_hsh <= r_h;
            r_cnt <= CNT_W'(MULT_CYC);
            if (w_is_aad) r_na_left <= r_na_left - 64'd1;
            else          r_nc_left <= r_nc_left - 64'd1;
          end
        end
        S_LEN: begin
          r_v     <= r_s ^ {r_aad_bits, r_text_bits};
          r_z     <= '0;
          r_hsh   <= r_h;
          r_cnt   <= CNT_W'(MULT_CYC);
          r_final <= 1'b1;
        end
        S_MULT: begin
          r_z   <= w_z;
          r_v   <= w_v;
          r_hsh <= w_hsh_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_mult_done) begin
            r_s <= w_z;
            if (r_final) begin
              r_tag       <= (w_z ^ r_ej0) & TAG_MASK;
              r_tag_valid <= 1'b1;
            end
          end
        end
        S_TAG: begin
          if (i_tag_ready) begin
            r_tag_valid <= 1'b0;
            r_tag       <= '0;
            r_s         <= '0;
            r_final     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_blk_ready = w_ready;
  assign o_tag_valid = r_tag_valid;
  assign o_tag       = r_tag;
  assign o_busy      = (r_state != S_IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_aes_gcm_ghash_engine.sv
// Bench for aes_gcm_ghash_engine: four instances (DIGIT_BITS 8/1/128/4, the last with a
// 96-bit tag) checked against NIST vectors and a textbook GHASH model.
module tb_aes_gcm_ghash_engine;

  localparam int ND = 4;
  localparam logic [0:127] H_TC   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [0:127] EJ0_TC = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [0:127] C_TC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [0:127] T_TC2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_s  [ND];
  logic [0:127] h_s      [ND];
  logic [0:127] ej0_s    [ND];
  logic [0:63]  abits_s  [ND];
  logic [0:63]  tbits_s  [ND];
  logic         valid_s  [ND];
  logic [0:127] data_s   [ND];
  logic         tready_s [ND];
  logic         rdy_o    [ND];
  logic         tv_o     [ND];
  logic [0:127] tag_o    [ND];
  logic         busy_o   [ND];
  logic         err_o    [ND];

  generate
    for (genvar g = 0; g < ND; g++) begin : g_dut
      aes_gcm_ghash_engine #(
        .DIGIT_BITS(g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 128 : 4),
        .TAG_BITS  (g == 3 ? 96 : 128)
      ) u_dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_start       (start_s[g]),
        .i_h           (h_s[g]),
        .i_encrypted_j0(ej0_s[g]),
        .i_aad_bits    (abits_s[g]),
        .i_text_bits   (tbits_s[g]),
        .i_blk_valid   (valid_s[g]),
        .o_blk_ready   (rdy_o[g]),
        .i_blk_data    (data_s[g]),
        .o_tag_valid   (tv_o[g]),
        .i_tag_ready   (tready_s[g]),
        .o_tag         (tag_o[g]),
        .o_busy        (busy_o[g]),
        .o_err         (err_o[g])
      );
    end
  endgenerate

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_cyc [ND] = '{0, 0, 0, 0};
  logic [0:127] blkq [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) for (int k = 0; k < ND; k++) if (rdy_o[k]) rdy_cyc[k] <= rdy_cyc[k] + 1;

  function automatic int mcyc(input int k);
    return (k == 0) ? 16 : (k == 1) ? 128 : (k == 2) ? 1 : 32;
  endfunction

  function automatic int tagbits(input int k);
    return (k == 3) ? 96 : 128;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [0:127] keep_first(input logic [0:127] x, input int m);
    for (int j = 0; j < 128; j++) if (j >= m) x[j] = 1'b0;
    return x;
  endfunction

  // Textbook GF(2^128) product from the GCM definition (bit 0 = x^0 coefficient).
  function automatic logic [0:127] gf_mul(input logic [0:127] x, input logic [0:127] y);
    logic [0:127] z, v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[i]) z = z ^ v;
      if (v[127]) v = (v >> 1) ^ {8'hE1, 120'd0};
      else        v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [0:127] ref_tag(input logic [0:127] h, input logic [0:127] ej0,
                                           input longint abits, input longint tbits, input int tb);
    int na, nc, am, tm;
    logic [0:127] s, x;
    na = int'((abits + 127) / 128);
    nc = int'((tbits + 127) / 128);
    am = int'(abits % 128);
    tm = int'(tbits % 128);
    s = '0;
    for (int i = 0; i < na + nc; i++) begin
      x = blkq[i];
      if (i == na - 1 && am != 0) x = keep_first(x, am);
      if (nc > 0 && i == na + nc - 1 && tm != 0) x = keep_first(x, tm);
      s = gf_mul(s ^ x, h);
    end
    x = {abits[63:0], tbits[63:0]};
    s = gf_mul(s ^ x, h);
    return keep_first(s ^ ej0, tb);
  endfunction

  task automatic run_msg(input int k, input logic [0:127] h, input logic [0:127] ej0,
                         input logic [0:63] abits, input logic [0:63] tbits,
                         input bit gaps, input bit bp, input bit err_mid, input bit start_at_tag,
                         output logic [0:127] tag, output int lat, output int nrdy);
    int c0, r0, n, wd;
    bit unstable;
    n = blkq.size();
    r0 = rdy_cyc[k];
    unstable = 0;
    @(negedge clk);
    h_s[k] = h; ej0_s[k] = ej0; abits_s[k] = abits; tbits_s[k] = tbits; start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    h_s[k] = rnd128();
    c0 = cyc;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          valid_s[k] = 1'b0; data_s[k] = rnd128();
          @(negedge clk);
        end
      end
      valid_s[k] = 1'b1; data_s[k] = blkq[i]; wd = 0;
      while (!rdy_o[k] && wd < 2000) begin @(negedge clk); wd++; end
      if (wd >= 2000) begin
        checks++; failures++;
        $display("FAIL blk_ready_timeout dut=%0d blk=%0d got=timeout exp=ready", k, i);
      end
      @(negedge clk);
      valid_s[k] = 1'b0; data_s[k] = rnd128();
    end
    if (err_mid) begin
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
      checks++;
      if (err_o[k] !== 1'b1) begin failures++; $display("FAIL err_pulse dut=%0d got=%b exp=1", k, err_o[k]); end
      @(negedge clk);
      checks++;
      if (err_o[k] !== 1'b0) begin failures++; $display("FAIL err_once dut=%0d got=%b exp=0", k, err_o[k]); end
    end
    wd = 0;
    while (!tv_o[k] && wd < 5000) begin @(negedge clk); wd++; end
    if (wd >= 5000) begin
      checks++; failures++;
      $display("FAIL tag_timeout dut=%0d got=timeout exp=tag_valid", k);
    end
    lat = cyc - c0 + 1;
    tag = tag_o[k];
    if (bp) begin
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        if (tag_o[k] !== tag || tv_o[k] !== 1'b1) unstable = 1;
      end
      checks++;
      if (unstable) begin failures++; $display("FAIL tag_stable dut=%0d got=%h exp=%h", k, tag_o[k], tag); end
    end
    tready_s[k] = 1'b1;
    if (start_at_tag) start_s[k] = 1'b1;
    @(negedge clk);
    tready_s[k] = 1'b0; start_s[k] = 1'b0;
    checks++;
    if (tv_o[k] !== 1'b0 || busy_o[k] !== 1'b0) begin
      failures++; $display("FAIL tag_release dut=%0d got=tv%b/busy%b exp=tv0/busy0", k, tv_o[k], busy_o[k]);
    end
    if (start_at_tag) begin
      checks++;
      if (err_o[k] !== 1'b1) begin failures++; $display("FAIL err_at_tag dut=%0d got=%b exp=1", k, err_o[k]); end
    end
    nrdy = rdy_cyc[k] - r0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (rdy_o[k] !== 0 || tv_o[k] !== 0 || tag_o[k] !== '0 || busy_o[k] !== 0 || err_o[k] !== 0) begin
        failures++;
        $display("FAIL reset_outputs dut=%0d got=rdy%b tv%b busy%b err%b tag=%h exp=all0", k, rdy_o[k], tv_o[k], busy_o[k], err_o[k], tag_o[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tc1();
    logic [0:127] tag, exp;
    int lat, nr;
    for (int k = 0; k < ND; k++) begin
      blkq.delete();
      exp = keep_first(EJ0_TC, tagbits(k));
      run_msg(k, H_TC, EJ0_TC, 64'd0, 64'd0, 0, 0, 0, 0, tag, lat, nr);
      checks++;
      if (tag !== exp) begin failures++; $display("FAIL tc1_tag dut=%0d got=%h exp=%h", k, tag, exp); end
      checks++;
      if (nr != 0) begin failures++; $display("FAIL tc1_no_ready dut=%0d got=%0d exp=0", k, nr); end
    end
  endtask

  task automatic test_tc2();
    logic [0:127] tag;
    int lat, nr, exp_lat;
    for (int k = 0; k < 3; k++) begin
      blkq.delete(); blkq.push_back(C_TC2);
      run_msg(k, H_TC, EJ0_TC, 64'd0, 64'd128, 0, 0, 0, 0, tag, lat, nr);
      exp_lat = 1 + 1 * (mcyc(k) + 1) + mcyc(k) + 1;
      checks++;
      if (tag !== T_TC2) begin failures++; $display("FAIL tc2_tag dut=%0d got=%h exp=%h", k, tag, T_TC2); end
      checks++;
      if (lat != exp_lat) begin failures++; $display("FAIL tc2_latency dut=%0d got=%0d exp=%0d", k, lat, exp_lat); end
    end
  endtask

  task automatic test_tag96();
    logic [0:127] tag, exp;
    int lat, nr;
    exp = T_TC2;
    exp[96:127] = '0;
    blkq.delete(); blkq.push_back(C_TC2);
    run_msg(3, H_TC, EJ0_TC, 64'd0, 64'd128, 0, 1, 0, 0, tag, lat, nr);
    checks++;
    if (tag !== exp) begin failures++; $display("FAIL tag96 dut=3 got=%h exp=%h", tag, exp); end
  endtask

  task automatic test_partial();
    logic [0:127] tag, exp, blk, zb;
    int lat, nr;
    for (int k = 0; k < 2; k++) begin
      blk = C_TC2; blk[120:127] = 8'hFF;
      zb  = C_TC2; zb[120:127]  = 8'h00;
      blkq.delete(); blkq.push_back(zb);
      exp = ref_tag(H_TC, EJ0_TC, 0, 120, 128);
      blkq.delete(); blkq.push_back(blk);
      run_msg(k, H_TC, EJ0_TC, 64'd0, 64'd120, 1, 1, 0, 0, tag, lat, nr);
      checks++;
      if (tag !== exp) begin failures++; $display("FAIL partial_tag dut=%0d got=%h exp=%h", k, tag, exp); end
    end
  endtask

  task automatic test_mixed();
    logic [0:127] tag, exp, h, ej0;
    longint ab, tb;
    int lat, nr, exp_lat;
    for (int k = 0; k < ND; k++) begin
      blkq.delete();
      repeat (5) blkq.push_back(rnd128());
      h = rnd128(); ej0 = rnd128();
      ab = 256 + longint'($urandom_range(1, 128));
      tb = 128 + longint'($urandom_range(1, 128));
      exp = ref_tag(h, ej0, ab, tb, tagbits(k));
      run_msg(k, h, ej0, ab, tb, 0, $urandom_range(0, 1) == 1, 0, 0, tag, lat, nr);
      exp_lat = 1 + 5 * (mcyc(k) + 1) + mcyc(k) + 1;
      checks++;
      if (tag !== exp) begin failures++; $display("FAIL mixed_tag dut=%0d got=%h exp=%h", k, tag, exp); end
      checks++;
      if (nr != 5) begin failures++; $display("FAIL mixed_ready_count dut=%0d got=%0d exp=5", k, nr); end
      checks++;
      if (lat != exp_lat) begin failures++; $display("FAIL mixed_latency dut=%0d got=%0d exp=%0d", k, lat, exp_lat); end
    end
  endtask

  task automatic test_protocol();
    logic [0:127] tag;
    int lat, nr;
    blkq.delete(); blkq.push_back(C_TC2);
    run_msg(0, H_TC, EJ0_TC, 64'd0, 64'd128, 0, 1, 1, 1, tag, lat, nr);
    checks++;
    if (tag !== T_TC2) begin failures++; $display("FAIL err_tag_unchanged dut=0 got=%h exp=%h", tag, T_TC2); end
  endtask

  task automatic test_reset_mid();
    logic [0:127] tag;
    int lat, nr, wd;
    @(negedge clk);
    h_s[0] = rnd128(); ej0_s[0] = rnd128(); abits_s[0] = 64'd256; tbits_s[0] = 64'd0;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    valid_s[0] = 1'b1; data_s[0] = rnd128(); wd = 0;
    while (!rdy_o[0] && wd < 100) begin @(negedge clk); wd++; end
    @(negedge clk);
    valid_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy_o[0] !== 0 || tv_o[0] !== 0 || tag_o[0] !== '0 || busy_o[0] !== 0 || err_o[0] !== 0) begin
      failures++;
      $display("FAIL reset_mid dut=0 got=rdy%b tv%b busy%b err%b exp=all0", rdy_o[0], tv_o[0], busy_o[0], err_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    blkq.delete();
    run_msg(0, H_TC, EJ0_TC, 64'd0, 64'd0, 0, 0, 0, 0, tag, lat, nr);
    checks++;
    if (tag !== EJ0_TC) begin failures++; $display("FAIL post_reset_tc1 dut=0 got=%h exp=%h", tag, EJ0_TC); end
  endtask

  task automatic test_back_to_back();
    logic [0:127] tag, exp, h, ej0;
    longint ab, tb;
    int lat, nr;
    for (int m = 0; m < 3; m++) begin
      blkq.delete();
      ab = longint'($urandom_range(0, 300));
      tb = longint'($urandom_range(0, 300));
      repeat (int'((ab + 127) / 128 + (tb + 127) / 128)) blkq.push_back(rnd128());
      h = rnd128(); ej0 = rnd128();
      exp = ref_tag(h, ej0, ab, tb, 128);
      run_msg(2, h, ej0, ab, tb, 1, 1, 0, 0, tag, lat, nr);
      checks++;
      if (tag !== exp) begin failures++; $display("FAIL b2b_tag msg=%0d got=%h exp=%h", m, tag, exp); end
    end
  endtask

  initial begin
    for (int k = 0; k < ND; k++) begin
      start_s[k] = 1'b0; h_s[k] = '0; ej0_s[k] = '0; abits_s[k] = '0; tbits_s[k] = '0;
      valid_s[k] = 1'b0; data_s[k] = '0; tready_s[k] = 1'b0;
    end
    test_reset();
    test_tc1();
    test_tc2();
    test_tag96();
    test_partial();
    test_mixed();
    test_protocol();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
